// File: rtl/axi_master_fsm.sv
// Shared state encoding and AXI field constants for the FFT AXI master.
package axi_master_fsm;

    typedef enum logic [2:0] {
        M_IDLE,
        M_AW,
        M_W,
        M_B,
        M_WAIT_CALC,
        M_AR,
        M_R,
        M_DONE
    } master_fsm;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/axi_fft_master.sv
// AXI master that bursts samples to an FFT core, waits for completion and
// bursts the results back out as a stream.
module axi_fft_master
    import axi_master_fsm::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_W_WIDTH = 2,
    parameter int ID_R_WIDTH = 2,
    parameter int TRANS_ID   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_START,
    input  logic [11:0]           i_SAMPLES_NUMBER,
    input  logic [15:0]           i_SRC_DATA,
    input  logic                  i_SRC_VALID,
    output logic                  o_SRC_READY,
    output logic [DATA_WIDTH-1:0] o_RES_DATA,
    output logic                  o_RES_VALID,
    input  logic                  i_RES_READY,
    input  logic                  i_CALC_END,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic [11:0]           o_AWADDR,
    output logic [7:0]            o_AWLEN,
    output logic [2:0]            o_AWSIZE,
    output logic [1:0]            o_AWBURST,
    output logic [ID_W_WIDTH-1:0] o_AWID,
    output logic                  o_AWVALID,
    input  logic                  i_AWREADY,
    output logic [15:0]           o_WDATA,
    output logic [1:0]            o_WSTRB,
    output logic                  o_WVALID,
    output logic                  o_WLAST,
    input  logic                  i_WREADY,
    input  logic                  i_BVALID,
    input  logic [ID_W_WIDTH-1:0] i_BID,
    output logic                  o_BREADY,
    output logic [11:0]           o_ARADDR,
    output logic [7:0]            o_ARLEN,
    output logic [2:0]            o_ARSIZE,
    output logic [1:0]            o_ARBURST,
    output logic [ID_R_WIDTH-1:0] o_ARID,
    output logic                  o_ARVALID,
    input  logic                  i_ARREADY,
    input  logic [DATA_WIDTH-1:0] i_RDATA,
    input  logic [ID_R_WIDTH-1:0] i_RID,
    input  logic                  i_RVALID,
    input  logic                  i_RLAST,
    output logic                  o_RREADY
);

    localparam logic [ID_W_WIDTH-1:0] AW_ID = ID_W_WIDTH'(TRANS_ID);
    localparam logic [ID_R_WIDTH-1:0] AR_ID = ID_R_WIDTH'(TRANS_ID);

    master_fsm  state_q, state_d;
    logic [7:0] len_q, len_d;   // burst length minus one (AXLEN encoding)
    logic [7:0] cnt_q, cnt_d;

    // Only the low byte of N matters and response IDs are not checked.
    logic unused_inputs;
    assign unused_inputs = ^{i_SAMPLES_NUMBER[11:8], i_BID, i_RID};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= M_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        o_SRC_READY = 1'b0;
        o_RES_DATA  = '0;
        o_RES_VALID = 1'b0;
        o_BUSY      = 1'b0;
        o_DONE      = 1'b0;
        o_AWADDR    = '0;
        o_AWLEN     = '0;
        o_AWSIZE    = '0;
        o_AWBURST   = '0;
        o_AWID      = '0;
        o_AWVALID   = 1'b0;
        o_WDATA     = '0;
        o_WSTRB     = '0;
        o_WVALID    = 1'b0;
        o_WLAST     = 1'b0;
        o_BREADY    = 1'b0;
        o_ARADDR    = '0;
        o_ARLEN     = '0;
        o_ARSIZE    = '0;
        o_ARBURST   = '0;
        o_ARID      = '0;
        o_ARVALID   = 1'b0;
        o_RREADY    = 1'b0;

        case (state_q)
            M_IDLE: begin
                if (i_START) begin
                    len_d   = i_SAMPLES_NUMBER[7:0] - 8'd1;
                    cnt_d   = '0;
                    state_d = M_AW;
                end
            end

            M_AW: begin
                o_BUSY    = 1'b1;
                o_AWVALID = 1'b1;
                o_AWLEN   = len_q;
                o_AWSIZE  = AXI_SIZE_2B;
                o_AWBURST = AXI_BURST_INCR;
                o_AWID    = AW_ID;
                if (i_AWREADY) begin
                    state_d = M_W;
                end
            end

            // Samples flow straight from the source stream onto W.
            M_W: begin
                o_BUSY      = 1'b1;
                o_WVALID    = i_SRC_VALID;
                o_SRC_READY = i_WREADY;
                o_WDATA     = i_SRC_DATA;
                o_WSTRB     = 2'b11;
                o_WLAST     = (cnt_q == len_q);
                if (i_SRC_VALID && i_WREADY) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = '0;
                        state_d = M_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            M_B: begin
                o_BUSY   = 1'b1;
                o_BREADY = 1'b1;
                if (i_BVALID) begin
                    state_d = M_WAIT_CALC;
                end
            end

            M_WAIT_CALC: begin
                o_BUSY = 1'b1;
                if (i_CALC_END) begin
                    state_d = M_AR;
                end
            end

            M_AR: begin
                o_BUSY    = 1'b1;
                o_ARVALID = 1'b1;
                o_ARLEN   = len_q;
                o_ARSIZE  = AXI_SIZE_4B;
                o_ARBURST = AXI_BURST_INCR;
                o_ARID    = AR_ID;
                if (i_ARREADY) begin
                    state_d = M_R;
                end
            end

            // Read data goes straight to the result stream; stop at RLAST or N beats.
            M_R: begin
                o_BUSY      = 1'b1;
                o_RREADY    = i_RES_READY;
                o_RES_VALID = i_RVALID;
                o_RES_DATA  = i_RDATA;
                if (i_RVALID && i_RES_READY) begin
                    if (i_RLAST || (cnt_q == len_q)) begin
                        cnt_d   = '0;
                        state_d = M_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            M_DONE: begin
                o_BUSY  = 1'b1;
                o_DONE  = 1'b1;
                state_d = M_IDLE;
            end

            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

endmodule

// File: doc/axi_fft_master.md
AXI_FFT_MASTER -- requirements
Module: axi_fft_master

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, read-data width; ID_W_WIDTH, 2, write-ID width; ID_R_WIDTH, 2, read-ID width; TRANS_ID, 0, ID driven on AWID/ARID.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_START  in  1  begin one write/compute/read job (sampled in IDLE only)
- i_SAMPLES_NUMBER  in  12  beats per burst N, legal 1..256; latched at start
- i_SRC_DATA / i_SRC_VALID / o_SRC_READY  in 16 / in 1 / out 1  sample input stream
- o_RES_DATA / o_RES_VALID / i_RES_READY  out DATA_WIDTH / out 1 / in 1  result output stream
- i_CALC_END  in  1  FFT core finished
- o_BUSY, o_DONE  out  1 each  job active; one-cycle job-complete pulse
- AW channel: o_AWADDR 12, o_AWLEN 8, o_AWSIZE 3, o_AWBURST 2, o_AWID ID_W_WIDTH, o_AWVALID 1 (out); i_AWREADY 1 (in)
- W channel: o_WDATA 16, o_WSTRB 2, o_WVALID 1, o_WLAST 1 (out); i_WREADY 1 (in)
- B channel: i_BVALID 1, i_BID ID_W_WIDTH (in); o_BREADY 1 (out)
- AR channel: o_ARADDR 12, o_ARLEN 8, o_ARSIZE 3, o_ARBURST 2, o_ARID ID_R_WIDTH, o_ARVALID 1 (out); i_ARREADY 1 (in)
- R channel: i_RDATA DATA_WIDTH, i_RID ID_R_WIDTH, i_RVALID 1, i_RLAST 1 (in); o_RREADY 1 (out)

Function
REQ-003 The FSM SHALL have states M_IDLE, M_AW, M_W, M_B, M_WAIT_CALC, M_AR, M_R, M_DONE.
REQ-004 In M_IDLE, i_START=1 SHALL latch N and enter M_AW; o_BUSY=1 in every state except M_IDLE.
REQ-005 In M_AW: o_AWVALID=1, AWADDR=0, AWLEN=N-1, AWSIZE=3'b001, AWBURST=2'b01, AWID=TRANS_ID; on AWVALID&AWREADY go to M_W.
REQ-006 AW/AR payloads SHALL remain stable while VALID=1 and not READY; VALID is never withdrawn before the handshake.
REQ-007 In M_W: o_WVALID=i_SRC_VALID, o_SRC_READY=i_WREADY, o_WDATA=i_SRC_DATA, o_WSTRB=2'b11; a beat transfers when WVALID&WREADY, and the beat counter increments (8-bit).
REQ-008 o_WLAST SHALL be 1 exactly on beat N-1; after the last beat transfers, go to M_B.
REQ-009 In M_B: o_BREADY=1; on i_BVALID go to M_WAIT_CALC; i_BID is ignored.
REQ-010 In M_WAIT_CALC, i_CALC_END=1 SHALL move to M_AR; i_CALC_END asserted earlier (during M_W/M_B) SHALL NOT be remembered.
REQ-011 In M_AR: o_ARVALID=1, ARADDR=0, ARLEN=N-1, ARSIZE=3'b010, ARBURST=2'b01, ARID=TRANS_ID; on handshake go to M_R.
REQ-012 In M_R: o_RREADY=i_RES_READY, o_RES_VALID=i_RVALID, o_RES_DATA=i_RDATA (combinational pass-through, zero latency); a beat counts on RVALID&RREADY.
REQ-013 M_R SHALL exit to M_DONE on the first handshaken beat with i_RLAST=1 or with count N-1, whichever comes first.
REQ-014 M_DONE SHALL last one cycle with o_DONE=1, then return to M_IDLE.
REQ-015 i_START outside M_IDLE SHALL be ignored.
REQ-016 N=1 SHALL produce AWLEN=ARLEN=0 and WLAST on the first beat; N outside 1..256 is illegal and unchecked (N[7:0]-1 used).
REQ-017 All VALID/READY outputs not named for the current state SHALL be 0; o_WDATA/o_RES_DATA are don't-care when their VALID=0.

Reset
REQ-018 On i_rstn=0, state SHALL become M_IDLE immediately, counters and latched N cleared to 0, and all outputs SHALL be 0.
REQ-019 Reset mid-burst SHALL abandon the transaction with no completion pulse; the next job starts from M_AW after a new i_START.

Structure
REQ-020 Package axi_master_fsm SHALL hold the state enum master_fsm and constants AXI_BURST_INCR=2'b01, AXI_SIZE_2B=3'b001, AXI_SIZE_4B=3'b010.
REQ-021 The block SHALL be a single module, one registered-state process plus one combinational next-state/output process; no sub-module.

Verification
REQ-022 N=4, sample source always valid, slave always ready -> AWLEN=3, 4 W beats, WLAST on the 4th, BREADY until BVALID, M_WAIT_CALC entered.
REQ-023 WREADY low for 2 cycles mid-burst -> WDATA/WLAST held stable, o_SRC_READY=0, no sample lost or duplicated.
REQ-024 i_CALC_END pulsed during M_B and again 5 cycles after BVALID -> AR issued only after the second pulse, ARLEN=3, ARSIZE=3'b010.
REQ-025 4 R beats 0xA0..0xA3, RLAST on the 4th, i_RES_READY toggling -> o_RES_DATA order A0..A3, single o_DONE pulse, return to M_IDLE.
REQ-026 N=1 end to end -> one W beat with WLAST=1, one R beat, o_DONE.
REQ-027 i_rstn asserted during the 3rd W beat -> all outputs 0 that cycle; a fresh i_START with N=2 completes normally.
